// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU's single-port unified memory between debug, load/store and
// instruction fetch. Each access runs IDLE -> ACCESS -> (WAIT) -> DONE.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,

    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic [1:0]        fsm_state,
    output logic [3:0]        starve_cnt
);

    // Handshake: a requester raises req with stable we/addr/wdata and holds them
    // until its gnt pulse; the request is latched on that grant, so req and
    // addr may change from the next cycle. done pulses once when the access
    // has completed; for reads rdata is valid during that pulse.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_DBG = 2'd0,
        OWN_LS  = 2'd1,
        OWN_IF  = 2'd2
    } owner_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wait_q, wait_d;
    logic [3:0]          starve_q, starve_d;
    logic [DATA_W-1:0]   rdata_d;

    logic                win_valid;
    owner_t              win_owner;

    // A starved fetch overrides the fixed dbg > ls > if order.
    always_comb begin
        win_valid = 1'b1;
        win_owner = OWN_DBG;
        if (if_req && (starve_q == STARVE_TOP)) begin
            win_owner = OWN_IF;
        end else if (dbg_req) begin
            win_owner = OWN_DBG;
        end else if (ls_req) begin
            win_owner = OWN_LS;
        end else if (if_req) begin
            win_owner = OWN_IF;
        end else begin
            win_valid = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wait_d   = wait_q;
        starve_d = starve_q;
        rdata_d  = rdata;

        unique case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    owner_d = win_owner;
                    state_d = S_ACCESS;
                    unique case (win_owner)
                        OWN_DBG: begin
                            we_d    = dbg_we;
                            addr_d  = dbg_addr;
                            wdata_d = dbg_wdata;
                        end
                        OWN_LS: begin
                            we_d    = ls_we;
                            addr_d  = ls_addr;
                            wdata_d = ls_wdata;
                        end
                        default: begin
                            we_d    = 1'b0;
                            addr_d  = if_addr;
                            wdata_d = '0;
                        end
                    endcase
                end
            end

            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    wait_d  = 4'd0;
                    state_d = S_WAIT;
                end
            end

            // wait_q counts WAIT cycles already spent; the last one is exactly
            // MEM_LAT cycles after ACCESS.
            S_WAIT: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == LAT_LAST) begin
                    rdata_d = mem_rdata;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (owner_q == OWN_IF) begin
                    starve_d = 4'd0;
                end else if (if_req && (starve_q != STARVE_TOP)) begin
                    starve_d = starve_q + 4'd1;
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_DBG;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_q   <= 4'd0;
            starve_q <= 4'd0;
            rdata    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            rdata    <= rdata_d;
        end
    end

    always_comb begin
        mem_en     = (state_q == S_ACCESS);
        mem_we     = (state_q == S_ACCESS) && we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;

        dbg_gnt    = (state_q == S_ACCESS) && (owner_q == OWN_DBG);
        ls_gnt     = (state_q == S_ACCESS) && (owner_q == OWN_LS);
        if_gnt     = (state_q == S_ACCESS) && (owner_q == OWN_IF);

        dbg_done   = (state_q == S_DONE) && (owner_q == OWN_DBG);
        ls_done    = (state_q == S_DONE) && (owner_q == OWN_LS);
        if_done    = (state_q == S_DONE) && (owner_q == OWN_IF);

        busy       = (state_q != S_IDLE);
        fsm_state  = state_q;
        starve_cnt = starve_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model checked every cycle,
// a latency-accurate memory responder, and directed requester scenarios.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 2;

  typedef struct {
    int          t0;
    int          tg;
    int          td;
    int          ngnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
  } res_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          dbg_req, dbg_we, dbg_gnt, dbg_done;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          ls_req, ls_we, ls_gnt, ls_done;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          if_req, if_gnt, if_done;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [1:0]    fsm_state;
  logic [3:0]    starve_cnt;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_done(ls_done),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy), .fsm_state(fsm_state), .starve_cnt(starve_cnt)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting, got nothing expected event (cycle %0d)", name, cyc);
  endtask

  // memory contents: fixed pattern unless written
  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] rsp_mem [logic [31:0]];
  logic [31:0] mdl_mem [logic [31:0]];

  function automatic logic [31:0] rsp_rd(input logic [31:0] a);
    if (rsp_mem.exists(a)) return rsp_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return init_val(a);
  endfunction

  // memory responder: data appears LAT cycles after the mem_en cycle, junk otherwise
  int          due_q[$];
  logic [31:0] dat_q[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      due_q.delete();
      dat_q.delete();
      mem_rdata = 32'hBAD0_0000;
    end else begin
      mem_rdata = 32'hBAD0_0000 + 32'(cyc);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        mem_rdata = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (mem_en) begin
        if (mem_we) rsp_mem[mem_addr] = mem_wdata;
        else begin
          due_q.push_back(cyc + LAT);
          dat_q.push_back(rsp_rd(mem_addr));
        end
      end
    end
  end

  // behavioural model: one transaction timeline at a time
  bit          m_active = 0;
  int          m_t0, m_done_at, m_owner, m_starve = 0, m_rel;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata = '0;
  logic [2:0]  e_gnt, e_done;
  logic        e_en, e_we;

  function automatic logic [2:0] onehot(input int who);
    return 3'b100 >> who;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt", 32'({dbg_gnt, ls_gnt, if_gnt}), 32'd0);
      check("rst_done", 32'({dbg_done, ls_done, if_done}), 32'd0);
      check1("rst_mem_en", mem_en, 1'b0);
      check1("rst_mem_we", mem_we, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_starve", 32'(starve_cnt), 32'd0);
      m_active = 0;
      m_starve = 0;
      m_rdata  = '0;
    end else begin
      e_gnt = 3'b000; e_done = 3'b000; e_en = 1'b0; e_we = 1'b0;
      m_rel = cyc - m_t0;
      if (m_active) begin
        if (m_rel == 1) begin
          e_gnt = onehot(m_owner);
          e_en  = 1'b1;
          e_we  = m_we;
        end
        if (cyc == m_done_at) begin
          e_done = onehot(m_owner);
          if (!m_we) m_rdata = mdl_rd(m_addr);
        end
      end
      check("gnt", 32'({dbg_gnt, ls_gnt, if_gnt}), 32'(e_gnt));
      check("done", 32'({dbg_done, ls_done, if_done}), 32'(e_done));
      check1("mem_en", mem_en, e_en);
      check1("mem_we", mem_we, e_we);
      check1("busy", busy, m_active);
      check("rdata", rdata, m_rdata);
      check("starve", 32'(starve_cnt), 32'(m_starve));
      if (m_active && m_rel == 1) begin
        check("mem_addr", mem_addr, m_addr);
        if (m_we) begin
          check("mem_wdata", mem_wdata, m_wdata);
          mdl_mem[m_addr] = m_wdata;
        end
      end
      // advance to next cycle
      if (m_active && cyc == m_done_at) begin
        if (m_owner == 2) m_starve = 0;
        else if (if_req && m_starve < SMAX) m_starve++;
        m_active = 0;
      end else if (!m_active) begin
        m_owner = -1;
        if (if_req && m_starve == SMAX) m_owner = 2;
        else if (dbg_req) m_owner = 0;
        else if (ls_req) m_owner = 1;
        else if (if_req) m_owner = 2;
        if (m_owner >= 0) begin
          m_active = 1;
          m_t0     = cyc;
          case (m_owner)
            0: begin m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; end
            1: begin m_we = ls_we;  m_addr = ls_addr;  m_wdata = ls_wdata;  end
            default: begin m_we = 1'b0; m_addr = if_addr; m_wdata = '0; end
          endcase
          m_done_at = cyc + (m_we ? 2 : 2 + LAT);
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input int who, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    case (who)
      0: begin dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
      1: begin ls_req = req; ls_we = we; ls_addr = addr; ls_wdata = wdata; end
      default: begin if_req = req; if_addr = addr; end
    endcase
  endtask

  function automatic logic gnt_of(input int who);
    return (who == 0) ? dbg_gnt : (who == 1) ? ls_gnt : if_gnt;
  endfunction

  function automatic logic done_of(input int who);
    return (who == 0) ? dbg_done : (who == 1) ? ls_done : if_done;
  endfunction

  task automatic issue(input int who, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output res_t r);
    bit got;
    r = '{default: 0};
    @(posedge clk); #1;
    drive(who, 1'b1, we, addr, wdata);
    @(negedge clk);
    r.t0 = cyc;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      if (gnt_of(who)) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      timeout("issue_gnt");
      drive(who, 1'b0, 1'b0, '0, '0);
      return;
    end
    r.tg    = cyc;
    r.ngnt  = 1;
    r.we    = mem_we;
    r.addr  = mem_addr;
    r.wdata = mem_wdata;
    @(posedge clk); #1;
    drive(who, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (gnt_of(who)) r.ngnt++;
      if (done_of(who)) begin
        r.td = cyc;
        r.rd = rdata;
        got = 1;
        break;
      end
    end
    if (!got) timeout("issue_done");
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  res_t r0, r1, r2, rs;
  int   ls_cnt, done_seen, en_seen;
  bit   got_g;

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    mem_rdata = '0;
    rst_n = 1'b0;

    // reset and idle
    idle_cycles(3);
    check1("reset_busy", busy, 1'b0);
    check1("reset_mem_en", mem_en, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cycles(5);
    check1("idle_busy", busy, 1'b0);
    check1("idle_mem_en", mem_en, 1'b0);

    // single fetch read
    issue(2, 1'b0, 32'h40, 32'h0, r0);
    check("rd_gnt_lat", r0.tg - r0.t0, 1);
    check("rd_done_lat", r0.td - r0.t0, 4);
    check("rd_data", r0.rd, 32'hDEADBEEF);
    check("rd_addr", r0.addr, 32'h40);
    check("rd_ngnt", r0.ngnt, 1);
    idle_cycles(2);

    // load/store write
    issue(1, 1'b1, 32'h100, 32'h12345678, r0);
    check("wr_gnt_lat", r0.tg - r0.t0, 1);
    check("wr_done_lat", r0.td - r0.t0, 2);
    check1("wr_mem_we", r0.we, 1'b1);
    check("wr_addr", r0.addr, 32'h100);
    check("wr_wdata", r0.wdata, 32'h12345678);
    check("wr_ngnt", r0.ngnt, 1);
    idle_cycles(2);

    // three simultaneous reads
    fork
      issue(0, 1'b0, 32'h40, 32'h0, r0);
      issue(1, 1'b0, 32'h100, 32'h0, r1);
      issue(2, 1'b0, 32'h104, 32'h0, r2);
    join
    check1("prio_dbg_before_ls", r0.tg < r1.tg, 1'b1);
    check1("prio_ls_before_if", r1.tg < r2.tg, 1'b1);
    check("prio_spacing_1", r1.tg - r0.tg, 3 + LAT);
    check("prio_spacing_2", r2.tg - r1.tg, 3 + LAT);
    check("prio_dbg_data", r0.rd, 32'hDEADBEEF);
    check("prio_ls_data", r1.rd, 32'h12345678);
    check("prio_if_data", r2.rd, 32'h5A5A_0104);
    idle_cycles(2);

    // fetch starved by a continuous load/store stream
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h300, 32'h0);
    ls_cnt = 0;
    fork
      issue(2, 1'b0, 32'h48, 32'h0, rs);
      begin
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (if_gnt) break;
          if (ls_gnt) ls_cnt++;
        end
      end
    join
    check("starve_ls_wins", ls_cnt, 2);
    check("starve_if_data", rs.rd, 32'h5A5A_0048);
    @(negedge clk);
    check("starve_cleared", 32'(starve_cnt), 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, '0, '0);
    idle_cycles(10);

    // reset during WAIT
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b0, 32'h80, 32'h0);
    got_g = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (if_gnt) begin got_g = 1; break; end
    end
    if (!got_g) timeout("rstwait_gnt");
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    idle_cycles(2);
    @(posedge clk); #1 rst_n = 1'b1;
    done_seen = 0;
    en_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dbg_done || ls_done || if_done) done_seen++;
      if (mem_en || mem_we) en_seen++;
    end
    check("rstwait_no_done", done_seen, 0);
    check("rstwait_no_mem_en", en_seen, 0);
    check1("rstwait_idle", busy, 1'b0);
    issue(2, 1'b0, 32'h44, 32'h0, r0);
    check("rstwait_done_lat", r0.td - r0.t0, 4);
    check("rstwait_data", r0.rd, 32'h5A5A_0044);
    idle_cycles(2);

    // debug write then load/store read-back
    issue(0, 1'b1, 32'h200, 32'hCAFEF00D, r0);
    check("dbgwr_done_lat", r0.td - r0.t0, 2);
    issue(1, 1'b0, 32'h200, 32'h0, r1);
    check("lsrd_data", r1.rd, 32'hCAFEF00D);
    check("lsrd_done_lat", r1.td - r1.t0, 4);
    issue(0, 1'b0, 32'h100, 32'h0, r2);
    check("dbgrd_data", r2.rd, 32'h12345678);
    idle_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

endmodule
